// File: rtl/sha_ctrl_pkg.sv
// sha_ctrl_pkg: shared states, default SHA sizing constants and a saturating counter helper
package sha_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, ROUND, ADD, CAPT, OUT} state_t;
  localparam int SHA256_WORD_W = 32;
  localparam int SHA256_ROUNDS = 64;
  localparam int SHA512_WORD_W = 64;
  localparam int SHA512_ROUNDS = 80;
  localparam int SHA_MSG_WORDS = 16;
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/sha_round_counter.sv
// sha_round_counter: wrapping 0..MAX-1 counter with clear, enable and terminal-count flag
module sha_round_counter #(
  parameter int W   = 4,
  parameter int MAX = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);
  assign tc = cnt == W'(MAX - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + W'(1);
endmodule

// File: rtl/sha_ctrl_multiblock.sv
// sha_ctrl_multiblock: multi-block SHA load/round/add sequencer; define SHA224_MODE_EN for the 224-bit digest mode
module sha_ctrl_multiblock
  import sha_ctrl_pkg::*;
#(
  parameter int WORD_W    = SHA256_WORD_W,
  parameter int ROUNDS    = SHA256_ROUNDS,
  parameter int MSG_WORDS = SHA_MSG_WORDS,
  localparam int RT_W     = $clog2(ROUNDS),
  localparam int HASH_W   = 8 * WORD_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] msg_data,
  input  logic              msg_valid,
  input  logic              msg_last,
  output logic              msg_ready,
  output logic              sched_we,
  output logic [3:0]        sched_addr,
  output logic [WORD_W-1:0] sched_wdata,
  output logic              sched_init,
  output logic              round_en,
  output logic [RT_W-1:0]   round_t,
  output logic              comp_init,
  output logic              comp_add,
  input  logic [HASH_W-1:0] hash_in,
  output logic [HASH_W-1:0] hash_out,
  output logic              hash_valid,
  input  logic              hash_ready,
  output logic              done,
  output logic              busy,
  output logic [15:0]       block_cnt,
`ifdef SHA224_MODE_EN
  input  logic              mode_224,
  output logic              comp_iv_sel,
`endif
  output logic              protocol_err
);
  state_t state, state_nx;
  logic start_go, accept, load_tc, round_tc, last_flag;
  logic [HASH_W-1:0] cap;
  assign start_go = state == IDLE && start && !abort;
  assign accept = state == LOAD && msg_valid;
  sha_round_counter #(.W(4), .MAX(MSG_WORDS)) u_load_cnt (
    .clk(clk), .reset_n(reset_n), .clr(abort || start_go), .en(accept),
    .cnt(sched_addr), .tc(load_tc)
  );
  sha_round_counter #(.W(RT_W), .MAX(ROUNDS)) u_round_cnt (
    .clk(clk), .reset_n(reset_n), .clr(abort), .en(state == ROUND),
    .cnt(round_t), .tc(round_tc)
  );
  always_comb begin
    msg_ready = state == LOAD;
    sched_we = accept;
    sched_wdata = accept ? msg_data : '0;
    sched_init = start_go || (state == ADD && !last_flag);
    comp_init = start_go;
    round_en = state == ROUND;
    comp_add = state == ADD;
    hash_valid = state == OUT;
    done = state == OUT && hash_ready && !abort;
    busy = state != IDLE;
    case (state)
      IDLE:    state_nx = start ? LOAD : IDLE;
      LOAD:    state_nx = accept && load_tc ? ROUND : LOAD;
      ROUND:   state_nx = round_tc ? ADD : ROUND;
      ADD:     state_nx = last_flag ? CAPT : LOAD;
      CAPT:    state_nx = OUT;
      OUT:     state_nx = hash_ready ? IDLE : OUT;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
`ifdef SHA224_MODE_EN
  logic mode_r;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) mode_r <= 1'b0;
    else if (start_go) mode_r <= mode_224;
  assign comp_iv_sel = mode_r;
  assign cap = mode_r ? {hash_in[HASH_W-1:WORD_W], {WORD_W{1'b0}}} : hash_in;
`else
  assign cap = hash_in;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      last_flag <= 1'b0;
      block_cnt <= '0;
      protocol_err <= 1'b0;
      hash_out <= '0;
    end else begin
      if (abort || start_go) last_flag <= 1'b0;
      else if (accept && load_tc) last_flag <= msg_last;
      if (abort || start_go) block_cnt <= '0;
      else if (state == ADD) block_cnt <= sat_inc16(block_cnt);
      if (start_go) protocol_err <= 1'b0;
      else if (accept && msg_last && !load_tc) protocol_err <= 1'b1;
      if (state == CAPT && !abort) hash_out <= cap;
    end
endmodule

// File: tb/tb_sha_ctrl_multiblock.sv
// tb_sha_ctrl_multiblock: drives the controller against a SHA-256 datapath stand-in and checks digests, timing and strobes
module tb_sha_ctrl_multiblock;
  typedef logic [0:7][31:0] st_t;
  typedef struct {
    int kind;
    int gap;
    int hold;
    logic [255:0] dig;
  } vec_t;
  localparam st_t IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic clk = 0, reset_n = 0, start = 0, abort = 0, msg_valid = 0, msg_last = 0, hash_ready = 0;
  logic [31:0] msg_data = 0;
  logic msg_ready, sched_we, sched_init, round_en, comp_init, comp_add, hash_valid, done, busy, protocol_err;
  logic [3:0] sched_addr;
  logic [31:0] sched_wdata, wn;
  logic [5:0] round_t;
  logic [255:0] hash_in, hash_out;
  logic [15:0] block_cnt;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, n_si = 0, n_ci = 0, n_done = 0, wd_bad = 0;
  int addr_q[$];
  logic [31:0] msg[64];

  always #5 clk = ~clk;

  sha_ctrl_multiblock dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .msg_data(msg_data), .msg_valid(msg_valid), .msg_last(msg_last), .msg_ready(msg_ready),
    .sched_we(sched_we), .sched_addr(sched_addr), .sched_wdata(sched_wdata), .sched_init(sched_init),
    .round_en(round_en), .round_t(round_t), .comp_init(comp_init), .comp_add(comp_add),
    .hash_in(hash_in), .hash_out(hash_out), .hash_valid(hash_valid), .hash_ready(hash_ready),
    .done(done), .busy(busy), .block_cnt(block_cnt), .protocol_err(protocol_err)
  );

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] s0f(input logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1f(input logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
  endfunction
  function automatic st_t rnd(input st_t s, input logic [31:0] w, input logic [31:0] k);
    logic [31:0] t1, t2;
    t1 = s[7] + (rr(s[4], 6) ^ rr(s[4], 11) ^ rr(s[4], 25)) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
    t2 = (rr(s[0], 2) ^ rr(s[0], 13) ^ rr(s[0], 22)) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
    return {t1 + t2, s[0], s[1], s[2], s[3] + t1, s[4], s[5], s[6]};
  endfunction
  function automatic st_t addv(input st_t a, input st_t b);
    st_t r;
    for (int j = 0; j < 8; j++) r[j] = a[j] + b[j];
    return r;
  endfunction

  // Stand-in for the sche/comp datapath, driven only by the controller's strobes
  st_t hreg = '0, av = '0;
  logic [31:0] wmem[64];
  assign hash_in = hreg;
  always_comb begin
    wn = wmem[round_t];
    if (round_t >= 6'd16)
      wn = s1f(wmem[round_t - 6'd2]) + wmem[round_t - 6'd7] + s0f(wmem[round_t - 6'd15]) + wmem[round_t - 6'd16];
  end
  always @(posedge clk) begin
    if (comp_init) begin
      hreg <= IV;
      av <= IV;
    end else if (comp_add) begin
      hreg <= addv(hreg, av);
      av <= addv(hreg, av);
    end else if (round_en) av <= rnd(av, wn, K[round_t]);
    if (sched_we) wmem[sched_addr] <= sched_wdata;
    if (round_en) wmem[round_t] <= wn;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sched_we) begin
      addr_q.push_back(int'(sched_addr));
      if (sched_wdata !== msg_data) wd_bad <= wd_bad + 1;
    end
    if (sched_init) n_si <= n_si + 1;
    if (comp_init) n_ci <= n_ci + 1;
    if (done) n_done <= n_done + 1;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Plain FIPS 180-4 compression over the raw blocks in msg[]
  task automatic ref_hash(input int nb, output logic [255:0] dig);
    st_t hh, s;
    logic [31:0] w[64];
    hh = IV;
    for (int b = 0; b < nb; b++) begin
      for (int t = 0; t < 64; t++)
        w[t] = t < 16 ? msg[b*16+t] : s1f(w[t-2]) + w[t-7] + s0f(w[t-15]) + w[t-16];
      s = hh;
      for (int t = 0; t < 64; t++) s = rnd(s, w[t], K[t]);
      hh = addv(hh, s);
    end
    dig = hh;
  endtask

  task automatic load_msg(input int kind);
    for (int i = 0; i < 64; i++) msg[i] = 0;
    if (kind == 0) begin
      msg[0] = 32'h61626380;
      msg[15] = 32'h00000018;
    end else begin
      for (int i = 0; i < 14; i++)
        msg[i] = {8'(8'h61 + i), 8'(8'h62 + i), 8'(8'h63 + i), 8'(8'h64 + i)};
      msg[14] = 32'h80000000;
      msg[31] = 32'h000001c0;
    end
  endtask

  task automatic run_msg(input int nb, input int gap, input int hold, input int bad_last,
                         input logic [255:0] exp_dig, input string tag);
    int t0, g, si0, ci0, dn0, wb0, bad;
    logic [255:0] h0;
    si0 = n_si; ci0 = n_ci; dn0 = n_done; wb0 = wd_bad; t0 = 0;
    addr_q.delete();
    start = 1;
    @(negedge clk);
    start = 0;
    chk({tag, " busy after start"}, 256'(busy), 256'(1));
    for (int i = 0; i < nb * 16; i++) begin
      g = 0;
      msg_valid = 0;
      while ((!msg_ready || $urandom_range(0, 99) < gap) && g < 500) begin
        @(negedge clk);
        g++;
      end
      msg_valid = 1;
      msg_data = msg[i];
      msg_last = (i == nb * 16 - 1) || (i == bad_last);
      if (i == 0) t0 = cyc;
      @(negedge clk);
    end
    msg_valid = 0; msg_last = 0; msg_data = 0;
    g = 0;
    while (!hash_valid && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk({tag, " hash_valid"}, 256'(hash_valid), 256'(1));
    if (gap == 0) chk({tag, " latency"}, 256'(cyc - t0), 256'(nb * 81 + 1));
    h0 = hash_out;
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      hash_ready = 0;
      start = (i == hold / 2);
      #1;
      if (!hash_valid || hash_out !== h0 || done) bad++;
      @(negedge clk);
    end
    start = 0;
    if (hold > 0) chk({tag, " hold stable"}, 256'(bad), 256'(0));
    hash_ready = 1;
    #1;
    chk({tag, " done"}, 256'(done), 256'(1));
    chk({tag, " digest"}, hash_out, exp_dig);
    chk({tag, " block_cnt"}, 256'(block_cnt), 256'(nb));
    @(negedge clk);
    hash_ready = 0;
    #1;
    chk({tag, " idle"}, 256'({busy, hash_valid, done}), 256'(0));
    chk({tag, " protocol_err"}, 256'(protocol_err), 256'(bad_last >= 0));
    chk({tag, " sched_init count"}, 256'(n_si - si0), 256'(nb));
    chk({tag, " comp_init count"}, 256'(n_ci - ci0), 256'(1));
    chk({tag, " done count"}, 256'(n_done - dn0), 256'(1));
    bad = addr_q.size() == nb * 16 ? 0 : 1;
    foreach (addr_q[i]) if (addr_q[i] != i % 16) bad++;
    chk({tag, " sched_addr sequence"}, 256'(bad), 256'(0));
    chk({tag, " sched_wdata"}, 256'(wd_bad - wb0), 256'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t tbl[4];
    int g, dn0, nb;
    logic [255:0] h0, d;
    tbl[0] = '{kind: 0, gap: 0,  hold: 0,  dig: DIG_ABC};
    tbl[1] = '{kind: 1, gap: 0,  hold: 0,  dig: DIG_TWO};
    tbl[2] = '{kind: 0, gap: 50, hold: 0,  dig: DIG_ABC};
    tbl[3] = '{kind: 0, gap: 0,  hold: 20, dig: DIG_ABC};
    repeat (3) @(negedge clk);
    chk("reset outputs", 256'({busy, msg_ready, hash_valid, sched_we, round_en, comp_add, done, protocol_err}), 256'(0));
    chk("reset hash_out", hash_out, 256'(0));
    chk("reset block_cnt", 256'(block_cnt), 256'(0));
    reset_n = 1;
    @(negedge clk);
    for (int v = 0; v < 4; v++) begin
      load_msg(tbl[v].kind);
      run_msg(tbl[v].kind + 1, tbl[v].gap, tbl[v].hold, -1, tbl[v].dig, $sformatf("vec%0d", v));
    end
    // protocol error: early msg_last, block still processed, flag sticky until next start
    load_msg(0);
    run_msg(1, 0, 0, 5, DIG_ABC, "early_last");
    repeat (3) @(negedge clk);
    chk("protocol_err sticky in IDLE", 256'(protocol_err), 256'(1));
    run_msg(1, 0, 0, -1, DIG_ABC, "after_err");
    // abort mid-round
    dn0 = n_done;
    h0 = hash_out;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 16; i++) begin
      msg_valid = 1;
      msg_data = msg[i];
      msg_last = (i == 15);
      @(negedge clk);
    end
    msg_valid = 0; msg_last = 0; msg_data = 0;
    g = 0;
    while (!(round_en && round_t == 6'd30) && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("reach round 30", 256'(round_t), 256'(30));
    abort = 1;
    @(negedge clk);
    abort = 0;
    #1;
    chk("abort to idle", 256'({busy, round_en, hash_valid}), 256'(0));
    repeat (100) @(negedge clk);
    chk("abort no done", 256'(n_done - dn0), 256'(0));
    chk("abort hash_out retained", hash_out, h0);
    chk("abort block_cnt cleared", 256'(block_cnt), 256'(0));
    run_msg(1, 0, 0, -1, DIG_ABC, "after_abort");
    // asynchronous reset in the middle of loading
    start = 1;
    @(negedge clk);
    start = 0;
    msg_valid = 1;
    repeat (5) @(negedge clk);
    #2;
    reset_n = 0;
    #1;
    chk("async reset", 256'({busy, msg_ready, sched_we, hash_valid}), 256'(0));
    chk("async reset hash_out", hash_out, 256'(0));
    msg_valid = 0;
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    // random multi-block messages against the reference
    for (int r = 0; r < 6; r++) begin
      nb = $urandom_range(1, 3);
      for (int i = 0; i < 64; i++) msg[i] = $urandom;
      ref_hash(nb, d);
      run_msg(nb, $urandom_range(0, 60), $urandom_range(0, 5), -1, d, $sformatf("rand%0d", r));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sha_ctrl_multiblock.md
Name:
sha_ctrl_multiblock

Overview:
Parametrised sequencing controller for the SHA hash core. It streams message words into the message schedule over a valid/ready handshake and steps the schedule and compression datapaths one round per clock. It chains any number of 512-bit (or 1024-bit) blocks and returns the final digest over a valid/ready output handshake. It sits between the bus-side IP wrapper and the sche/comp datapath, replacing the single-block controller with a synchronous round counter and explicit block chaining.

Parameters:
WORD_W, 32, datapath word width; 32 for SHA-256, 64 for SHA-512.
ROUNDS, 64, compression rounds per block; 64 or 80.
MSG_WORDS, 16, message words per block.
RT_W, $clog2(ROUNDS), round index width (localparam).
HASH_W, 8*WORD_W, digest width (localparam).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  begin a new message; honoured only in IDLE
abort  in  1  synchronous abort; returns to IDLE from any state
msg_data  in  WORD_W  message word
msg_valid  in  1  msg_data valid
msg_last  in  1  with the final word of the final block
msg_ready  out  1  controller accepts a word this cycle
sched_we  out  1  schedule write strobe
sched_addr  out  4  schedule write address, 0..MSG_WORDS-1
sched_wdata  out  WORD_W  schedule write data
sched_init  out  1  one-cycle pulse that clears schedule state before each block
round_en  out  1  advance schedule and compression by one round
round_t  out  RT_W  current round index
comp_init  out  1  one-cycle pulse that loads the IV into H, first block only
comp_add  out  1  one-cycle pulse that adds working variables into H
hash_in  in  HASH_W  H registers from comp
hash_out  out  HASH_W  registered digest
hash_valid  out  1  digest available
hash_ready  in  1  consumer accepts digest
done  out  1  one-cycle pulse on digest handshake
busy  out  1  state != IDLE
block_cnt  out  16  blocks completed in current message, saturating at 16'hFFFF
protocol_err  out  1  sticky; cleared by start

Behaviour:
- Reset (async): state=IDLE; every output 0; hash_out=0; counters 0.
- Single registered FSM with states IDLE, LOAD, ROUND, ADD, CAPT, OUT.
- IDLE:
  - start=1 -> LOAD.
  - comp_init and sched_init pulse during this cycle.
  - block_cnt and protocol_err are cleared.
- LOAD:
  - msg_ready=1.
  - On msg_valid&&msg_ready: sched_we=1 combinationally in the same cycle, sched_addr=load_cnt, sched_wdata=msg_data, then load_cnt++.
  - sched_wdata=0 when no write occurs.
  - When word MSG_WORDS-1 is accepted: latch last_flag=msg_last, clear load_cnt, go to ROUND with round_cnt=0.
  - msg_last on any other word: protocol_err<=1, word accepted normally.
  - msg_valid gaps stall LOAD indefinitely.
- ROUND:
  - round_en=1 every cycle; round_t=round_cnt.
  - round_cnt increments; at ROUNDS-1 -> ADD.
  - Exactly ROUNDS cycles; no wrap beyond ROUNDS-1.
- ADD:
  - comp_add=1 for one cycle; block_cnt++ (saturating).
  - last_flag=1 -> CAPT.
  - last_flag=0 -> LOAD, with sched_init pulsed in this cycle; comp_init is not pulsed, so H chains.
- CAPT:
  - One cycle; hash_out<=hash_in, which is already updated by comp_add.
  - Go to OUT.
- OUT:
  - hash_valid=1; hash_out stable.
  - hash_ready=1 -> done pulse and IDLE on the next clock.
  - hash_ready held low keeps OUT and hash_out stable.
- Latency:
  - Per block: MSG_WORDS+ROUNDS+1 cycles with no stalls.
  - hash_valid rises 2 cycles after the ADD of the final block.
- start outside IDLE is ignored; start and abort together in IDLE: abort wins.
- abort: next state IDLE; counters cleared; hash_valid dropped; hash_out retained; no done pulse.
- reset_n low mid-operation: immediate async return to reset values.

Optional Feature:
SHA224_MODE_EN
- Defined: adds input mode_224 (1 bit), sampled on start, and output comp_iv_sel (1 bit), registered and driven to comp with comp_init.
  - In 224 mode, hash_out keeps the upper 7*WORD_W bits of hash_in and zeroes the lowest WORD_W bits.
- Undefined: neither port exists; full-width digest only.

Decomposition:
- Package sha_ctrl_pkg holds:
  - state enum (IDLE..OUT);
  - SHA-256 and SHA-512 default parameter constants (WORD_W, ROUNDS);
  - MSG_WORDS constant;
  - a saturating-increment function.
- One sub-module is natural: sha_round_counter, a parametrised counter with init/enable and a terminal-count flag, shared by the load counter and the round counter.

Test Plan:
- Single padded "abc" block, msg_last on word 15, hash_ready=1 -> hash_out=ba7816bf...f20015ad; hash_valid exactly 82 cycles after the first word, without stalls; block_cnt=1; comp_init pulses once.
- Two-block "abcdbcdecdefdefg..." (448-bit) message -> digest 248d6a61...19db06c1; sched_init pulses twice, comp_init once, block_cnt=2.
- Random msg_valid gaps (50% duty) on the "abc" message -> same digest; sched_addr sequence 0..15 with no duplicates or skips.
- abort asserted at round_t=30 -> IDLE next cycle, round_en=0, no done; a following start/"abc" gives the correct digest.
- msg_last on word 5 -> protocol_err=1 sticky until the next start; block still processed.
- hash_ready held low 20 cycles in OUT -> hash_valid and hash_out stable; done pulses once on the handshake; start during OUT is ignored.
